// File: rtl/biquad_ctrl_pkg.sv
// Shared encodings for the biquad sequencer: FSM states and the datapath
// mux select codes for coefficient, operand and accumulator seed.
package biquad_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CAP  = 4'd1,
    ST_F1   = 4'd2,
    ST_F2   = 4'd3,
    ST_FST  = 4'd4,
    ST_Y0   = 4'd5,
    ST_Y1   = 4'd6,
    ST_Y2   = 4'd7,
    ST_YST  = 4'd8,
    ST_DONE = 4'd9
  } state_t;

  localparam logic [2:0] SEL_ZERO = 3'd0;
  localparam logic [2:0] SEL_A1   = 3'd1;
  localparam logic [2:0] SEL_A2   = 3'd2;
  localparam logic [2:0] SEL_B0   = 3'd3;
  localparam logic [2:0] SEL_B1   = 3'd4;
  localparam logic [2:0] SEL_B2   = 3'd5;

  localparam logic [1:0] OP_ZERO  = 2'd0;
  localparam logic [1:0] OP_FK1   = 2'd1;
  localparam logic [1:0] OP_FK2   = 2'd2;
  localparam logic [1:0] OP_FK    = 2'd3;

  localparam logic [1:0] SEED_ZERO = 2'd0;
  localparam logic [1:0] SEED_UK   = 2'd1;
  localparam logic [1:0] SEED_YK   = 2'd2;

  // States that drive the shared MAC and dwell MAC_WAIT+1 cycles.
  function automatic logic is_mac(input state_t s);
    return (s == ST_F1) || (s == ST_F2) || (s == ST_Y0) ||
           (s == ST_Y1) || (s == ST_Y2);
  endfunction

endpackage

// File: rtl/biquad_ctrl_if.sv
// Select/strobe bundle between the biquad sequencer (master) and the
// datapath mux plus sample-rate source (slave).
interface biquad_ctrl_if;
  logic       start;
  logic [2:0] controlS;
  logic [1:0] controlC;
  logic [1:0] controlZ;
  logic       uk_ld;
  logic       acc_init;
  logic       acc_en;
  logic       fk_ld;
  logic       yk_ld;
  logic       hist_shift;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    input  start,
    output controlS, controlC, controlZ,
    output uk_ld, acc_init, acc_en, fk_ld, yk_ld, hist_shift,
    output busy, done, overrun
  );

  modport slave (
    output start,
    input  controlS, controlC, controlZ,
    input  uk_ld, acc_init, acc_en, fk_ld, yk_ld, hist_shift,
    input  busy, done, overrun
  );
endinterface

// File: rtl/biquad_ctrl.sv
// Biquad IIR sequencer: walks the single-MAC datapath through the feedback
// and feedforward sections per sample request, with Moore-decoded selects.
module biquad_ctrl
  import biquad_ctrl_pkg::*;
#(
  parameter int MAC_WAIT = 0
) (
  input  logic          clk,
  input  logic          reset,
  biquad_ctrl_if.master bus
);

  localparam logic [2:0] WAIT_INIT = 3'(MAC_WAIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_wait;
  logic [2:0] w_wait_nxt;
  logic       r_overrun;
  logic       w_last;
  logic       w_busy;

  logic [2:0] w_sel_s;
  logic [1:0] w_sel_c;
  logic [1:0] w_sel_z;
  logic       w_uk_ld;
  logic       w_acc_init;
  logic       w_acc_en;
  logic       w_fk_ld;
  logic       w_yk_ld;
  logic       w_hist_shift;
  logic       w_done;

  assign w_last = (r_wait == 3'd0);
  assign w_busy = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_wait    <= 3'd0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (bus.start && w_busy)
        r_overrun <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_CAP;
      ST_CAP:  w_state_nxt = ST_F1;
      ST_F1:   if (w_last) w_state_nxt = ST_F2;
      ST_F2:   if (w_last) w_state_nxt = ST_FST;
      ST_FST:  w_state_nxt = ST_Y0;
      ST_Y0:   if (w_last) w_state_nxt = ST_Y1;
      ST_Y1:   if (w_last) w_state_nxt = ST_Y2;
      ST_Y2:   if (w_last) w_state_nxt = ST_YST;
      ST_YST:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // Reload on entry to each MAC state; count down while dwelling.
    if ((w_state_nxt != r_state) && is_mac(w_state_nxt))
      w_wait_nxt = WAIT_INIT;
    else if (is_mac(r_state) && !w_last)
      w_wait_nxt = r_wait - 3'd1;
  end

  always_comb begin
    w_sel_s      = SEL_ZERO;
    w_sel_c      = OP_ZERO;
    w_sel_z      = SEED_ZERO;
    w_uk_ld      = 1'b0;
    w_acc_init   = 1'b0;
    w_acc_en     = 1'b0;
    w_fk_ld      = 1'b0;
    w_yk_ld      = 1'b0;
    w_hist_shift = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_CAP: w_uk_ld = 1'b1;
      ST_F1: begin
        w_sel_z    = SEED_UK;
        w_sel_s    = SEL_A1;
        w_sel_c    = OP_FK1;
        w_acc_init = w_last;
      end
      ST_F2: begin
        w_sel_s  = SEL_A2;
        w_sel_c  = OP_FK2;
        w_acc_en = w_last;
      end
      ST_FST: w_fk_ld = 1'b1;
      ST_Y0: begin
        w_sel_s    = SEL_B0;
        w_sel_c    = OP_FK;
        w_acc_init = w_last;
      end
      ST_Y1: begin
        w_sel_s  = SEL_B1;
        w_sel_c  = OP_FK1;
        w_acc_en = w_last;
      end
      ST_Y2: begin
        w_sel_s  = SEL_B2;
        w_sel_c  = OP_FK2;
        w_acc_en = w_last;
      end
      ST_YST: begin
        w_yk_ld      = 1'b1;
        w_hist_shift = 1'b1;
      end
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.controlS   = w_sel_s;
  assign bus.controlC   = w_sel_c;
  assign bus.controlZ   = w_sel_z;
  assign bus.uk_ld      = w_uk_ld;
  assign bus.acc_init   = w_acc_init;
  assign bus.acc_en     = w_acc_en;
  assign bus.fk_ld      = w_fk_ld;
  assign bus.yk_ld      = w_yk_ld;
  assign bus.hist_shift = w_hist_shift;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_biquad_ctrl.sv
// Randomized bench for biquad_ctrl: two instances (MAC_WAIT 0 and 2) against a
// schedule model, plus a bench-side datapath checked against the filter equations.
module tb_biquad_ctrl;

  localparam int     F  = 14;
  localparam longint A1 = 16957;
  localparam longint A2 = -6026;
  localparam longint B0 = 9841;
  localparam longint B1 = 19682;
  localparam longint B2 = 9841;

  typedef struct packed {
    logic [2:0] s;
    logic [1:0] c;
    logic [1:0] z;
    logic       uk;
    logic       ai;
    logic       ae;
    logic       fl;
    logic       yl;
    logic       hs;
    logic       dn;
  } rec_t;

  logic clk;
  logic reset;
  logic r_start;
  logic dp_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  biquad_ctrl_if if0 ();
  biquad_ctrl_if if2 ();
  assign if0.start = r_start;
  assign if2.start = r_start;

  biquad_ctrl #(.MAC_WAIT(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  biquad_ctrl #(.MAC_WAIT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  rec_t o0, o2;
  assign o0 = {if0.controlS, if0.controlC, if0.controlZ, if0.uk_ld, if0.acc_init,
               if0.acc_en, if0.fk_ld, if0.yk_ld, if0.hist_shift, if0.done};
  assign o2 = {if2.controlS, if2.controlC, if2.controlZ, if2.uk_ld, if2.acc_init,
               if2.acc_en, if2.fk_ld, if2.yk_ld, if2.hist_shift, if2.done};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Datapath driven by the MAC_WAIT=0 instance.
  longint u_in, uk_r, acc, fk, fk1, fk2, yk;
  longint ms, mc, mz;

  always_comb begin
    ms = 0;
    mc = 0;
    mz = 0;
    case (if0.controlS)
      3'd1: ms = A1;
      3'd2: ms = A2;
      3'd3: ms = B0;
      3'd4: ms = B1;
      3'd5: ms = B2;
      default: ms = 0;
    endcase
    case (if0.controlC)
      2'd1: mc = fk1;
      2'd2: mc = fk2;
      2'd3: mc = fk;
      default: mc = 0;
    endcase
    case (if0.controlZ)
      2'd1: mz = uk_r <<< F;
      2'd2: mz = yk <<< F;
      default: mz = 0;
    endcase
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      uk_r <= 0; acc <= 0; fk <= 0; fk1 <= 0; fk2 <= 0; yk <= 0;
    end else begin
      if (if0.uk_ld) uk_r <= u_in;
      if (if0.acc_init) acc <= mz + ms * mc;
      else if (if0.acc_en) acc <= acc + ms * mc;
      if (if0.fk_ld) fk <= sat16(acc >>> F);
      if (if0.yk_ld) yk <= sat16(acc >>> F);
      if (if0.hist_shift) begin
        fk2 <= fk1;
        fk1 <= fk;
      end
    end
  end

  // Reference model: t = cycles since the accepted start (0 = idle).
  int     t0, t2;
  bit     ovr0, ovr2;
  longint rf1, rf2;

  function automatic rec_t exp_rec(input int t, input int w);
    rec_t r;
    int   k;
    r = '0;
    if (t == 0) return r;
    if (t == 1) begin r.uk = 1'b1; return r; end
    k = t - 2;
    if (k <= w) begin r.s = 3'd1; r.c = 2'd1; r.z = 2'd1; r.ai = (k == w); return r; end
    k -= w + 1;
    if (k <= w) begin r.s = 3'd2; r.c = 2'd2; r.ae = (k == w); return r; end
    k -= w + 1;
    if (k == 0) begin r.fl = 1'b1; return r; end
    k -= 1;
    if (k <= w) begin r.s = 3'd3; r.c = 2'd3; r.ai = (k == w); return r; end
    k -= w + 1;
    if (k <= w) begin r.s = 3'd4; r.c = 2'd1; r.ae = (k == w); return r; end
    k -= w + 1;
    if (k <= w) begin r.s = 3'd5; r.c = 2'd2; r.ae = (k == w); return r; end
    k -= w + 1;
    if (k == 0) begin r.yl = 1'b1; r.hs = 1'b1; end
    else r.dn = 1'b1;
    return r;
  endfunction

  task automatic upd(inout int t, inout bit ovr, input int w, input logic s, input logic rn);
    bit busy;
    if (!rn) begin
      t   = 0;
      ovr = 1'b0;
    end else begin
      busy = (t != 0);
      if (busy) t = (t == 9 + 5 * w) ? 0 : t + 1;
      if (s) begin
        if (busy) ovr = 1'b1;
        else t = 1;
      end
    end
  endtask

  task automatic check_cycle();
    rec_t   e0, e2;
    longint f, y;
    e0 = exp_rec(t0, 0);
    e2 = exp_rec(t2, 2);
    chk("w0_outputs", 32'(o0), 32'(e0));
    chk("w0_busy", 32'(if0.busy), 32'(t0 != 0));
    chk("w0_overrun", 32'(if0.overrun), 32'(ovr0));
    chk("w2_outputs", 32'(o2), 32'(e2));
    chk("w2_busy", 32'(if2.busy), 32'(t2 != 0));
    chk("w2_overrun", 32'(if2.overrun), 32'(ovr2));
    chk("w0_strobe_excl",
        32'($countones({if0.uk_ld, if0.acc_init, if0.acc_en, if0.fk_ld, if0.yk_ld}) <= 1), 32'd1);
    if (e0.dn) begin
      f = sat16(((u_in <<< F) + A1 * rf1 + A2 * rf2) >>> F);
      y = sat16((B0 * f + B1 * rf1 + B2 * rf2) >>> F);
      chk("yk_golden", 32'(yk), 32'(y));
      rf2  = rf1;
      rf1  = f;
      u_in = longint'($urandom_range(8000)) - 4000;
    end
  endtask

  task automatic cyc(input logic s, input logic rn);
    @(negedge clk);
    check_cycle();
    r_start = s;
    reset   = rn;
    @(posedge clk);
    upd(t0, ovr0, 0, s, rn);
    upd(t2, ovr2, 2, s, rn);
  endtask

  initial begin
    reset   = 1'b0;
    r_start = 1'b0;
    dp_clr  = 1'b1;
    u_in    = 4096;
    t0 = 0; t2 = 0; ovr0 = 1'b0; ovr2 = 1'b0;
    rf1 = 0; rf2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    dp_clr = 1'b0;

    // reset release, single sample
    repeat (2) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (22) cyc(1'b0, 1'b1);

    // second start in cycle 5
    cyc(1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (20) cyc(1'b0, 1'b1);

    // reset in Y1, then a normal sequence
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (22) cyc(1'b0, 1'b1);

    // four starts spaced 10 cycles
    cyc(1'b0, 1'b0);
    repeat (4) begin
      cyc(1'b1, 1'b1);
      repeat (9) cyc(1'b0, 1'b1);
    end
    repeat (12) cyc(1'b0, 1'b1);

    // random starts and occasional resets
    repeat (400) cyc($urandom_range(7) == 0, $urandom_range(99) != 0);

    // start held high
    repeat (30) cyc(1'b1, 1'b1);
    repeat (25) cyc(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
